iic_reg_access: RTL

- Transaction sequencer upstream of IicMaster's command FIFO and downstream of its data FIFO.
- Converts one register-level request (slave addr, internal addr, burst length, write or read) into the 10-bit IIC command word stream.
- Consumes the 9-bit per-byte result entries, returning read bytes on a stream port and reporting ACK errors per transaction.
- Lets software/state machines access IicSlave-style register devices without hand-building START/byte/STOP words.

---
 rtl/iic_pkg.sv | 29 ++
 rtl/iic_rsp_tracker.sv | 48 ++++
 rtl/iic_reg_access.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/iic_pkg.sv
// Shared constants and types for the IIC register-access sequencer.
// Command words follow IicMaster's 10-bit {ctl, byte, ack} format.
package iic_pkg;

  localparam logic [9:0] CMD_START = 10'b1_0000_0000_0;
  localparam logic [9:0] CMD_STOP  = 10'b1_1000_0000_0;
  localparam int         ACK_BIT   = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START1,
    S_SAW,
    S_IA,
    S_WDAT,
    S_START2,
    S_SAR,
    S_RDAT,
    S_STOP,
    S_DRAIN
  } state_t;

  function automatic logic [9:0] mk_byte_cmd(
    input logic [7:0] b,
    input logic       ackbit
  );
    return {1'b0, b, ackbit};
  endfunction

endpackage

// File: rtl/iic_rsp_tracker.sv
// Retires data-FIFO result entries for the active transaction.
// Read-data entries go to the stream port; the rest feed the error flag.
module iic_rsp_tracker #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          active,
  input  logic          rd,
  input  logic [CW-1:0] exp_cnt,
  input  logic [8:0]    dat_din,
  input  logic          dat_empty,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          dat_read,
  output logic          err_acc,
  output logic          retired
);
  import iic_pkg::*;

  logic [CW-1:0] rsp_cnt;
  logic          pending;
  logic          is_rdat;

  assign pending  = active && (rsp_cnt < exp_cnt);
  assign is_rdat  = rd && (rsp_cnt >= CW'(3));
  assign rd_valid = pending && is_rdat && !dat_empty;
  assign rd_data  = rd_valid ? dat_din[7:0] : 8'h00;
  assign dat_read = pending && !dat_empty && (!is_rdat || rd_ready);
  assign retired  = (rsp_cnt == exp_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_cnt <= '0;
      err_acc <= 1'b0;
    end else if (clear) begin
      rsp_cnt <= '0;
      err_acc <= 1'b0;
    end else if (dat_read) begin
      rsp_cnt <= rsp_cnt + CW'(1);
      if (!is_rdat)
        err_acc <= err_acc | dat_din[ACK_BIT];
    end
  end

endmodule

// File: rtl/iic_reg_access.sv
// Register-level request to IIC command stream sequencer.
// Emits START/addr/ia/data/STOP words and retires per-byte results.
module iic_reg_access #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rd,
  input  logic [6:0]       req_sa,
  input  logic [7:0]       req_ia,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [7:0]       wd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err,
  output logic [9:0]       cmd_dout,
  output logic             cmd_write,
  input  logic             cmd_full,
  input  logic [8:0]       dat_din,
  output logic             dat_read,
  input  logic             dat_empty
);
  import iic_pkg::*;

  localparam int CW = LEN_W + 2;

  state_t           state, nxt;
  logic             up;
  logic             rd_q;
  logic [6:0]       sa_q;
  logic [7:0]       ia_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             last;
  logic             hs;
  logic             err_acc;
  logic             retired;
  logic [CW-1:0]    exp_cnt;

  assign hs      = (state == S_IDLE) && req_valid && up;
  assign last    = (cnt == len_q - LEN_W'(1));
  assign exp_cnt = CW'(len_q) + (rd_q ? CW'(3) : CW'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // A zero-length read is still one byte on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up    <= 1'b0;
      rd_q  <= 1'b0;
      sa_q  <= '0;
      ia_q  <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      up <= 1'b1;
      if (hs) begin
        rd_q  <= req_rd;
        sa_q  <= req_sa;
        ia_q  <= req_ia;
        len_q <= (req_rd && req_len == '0) ? LEN_W'(1) : req_len;
      end
      if (state != S_WDAT && state != S_RDAT)
        cnt <= '0;
      else if (cmd_write)
        cnt <= cnt + LEN_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (hs) nxt = S_START1;
      S_START1: if (!cmd_full) nxt = S_SAW;
      S_SAW:    if (!cmd_full) nxt = S_IA;
      S_IA: begin
        if (!cmd_full)
          nxt = rd_q ? S_START2 :
                (len_q == '0) ? S_STOP : S_WDAT;
      end
      S_WDAT:   if (wd_valid && !cmd_full && last) nxt = S_STOP;
      S_START2: if (!cmd_full) nxt = S_SAR;
      S_SAR:    if (!cmd_full) nxt = S_RDAT;
      S_RDAT:   if (!cmd_full && last) nxt = S_STOP;
      S_STOP:   if (!cmd_full) nxt = S_DRAIN;
      S_DRAIN:  if (retired) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    cmd_write = 1'b0;
    cmd_dout  = 10'h000;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE:   req_ready = up;
      S_START1: begin
        cmd_dout  = CMD_START;
        cmd_write = !cmd_full;
      end
      S_SAW: begin
        cmd_dout  = mk_byte_cmd({sa_q, 1'b0}, 1'b1);
        cmd_write = !cmd_full;
      end
      S_IA: begin
        cmd_dout  = mk_byte_cmd(ia_q, 1'b1);
        cmd_write = !cmd_full;
      end
      S_WDAT: begin
        cmd_dout  = mk_byte_cmd(wd_data, 1'b1);
        wd_ready  = !cmd_full;
        cmd_write = wd_valid && !cmd_full;
      end
      S_START2: begin
        cmd_dout  = CMD_START;
        cmd_write = !cmd_full;
      end
      S_SAR: begin
        cmd_dout  = mk_byte_cmd({sa_q, 1'b1}, 1'b1);
        cmd_write = !cmd_full;
      end
      S_RDAT: begin
        cmd_dout  = mk_byte_cmd(8'hFF, last);
        cmd_write = !cmd_full;
      end
      S_STOP: begin
        cmd_dout  = CMD_STOP;
        cmd_write = !cmd_full;
      end
      S_DRAIN: begin
        done = retired;
        err  = retired && err_acc;
      end
      default: ;
    endcase
  end

  iic_rsp_tracker #(.CW(CW)) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .clear     (hs),
    .active    (state != S_IDLE),
    .rd        (rd_q),
    .exp_cnt   (exp_cnt),
    .dat_din   (dat_din),
    .dat_empty (dat_empty),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .dat_read  (dat_read),
    .err_acc   (err_acc),
    .retired   (retired)
  );

endmodule
